gc_response_sequencer: RTL and testbench

Command/response sequencer for the GameCube controller bus, between the bit-level receiver and the bit-level transmitter inside the controller top. It collects the received command bytes, validates each frame at its stop bit, and builds the response image (tx_buffer/tx_bit_total) from live button/stick inputs and latched origin values. After the bus turnaround delay it starts the transmitter and holds the image stable until the transmitter reports done. It also owns the rumble register and the origin (calibration) registers.

---
 rtl/gc_response_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_gc_response_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gc_response_sequencer.sv
// gc_response_sequencer: collects GameCube controller bus command frames,
// validates them at the stop bit, builds the response image from live and
// calibrated inputs, waits out the bus turnaround, then starts the
// transmitter and holds the image until the transmitter reports done.
`timescale 1ns/1ps
module gc_response_sequencer #(
  parameter int TURNAROUND_CYCLES = 80,
  parameter int RX_TIMEOUT_CYCLES = 4000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_stop,
  input  logic [11:0] btn,
  input  logic [7:0]  joy_x,
  input  logic [7:0]  joy_y,
  input  logic [7:0]  cstick_x,
  input  logic [7:0]  cstick_y,
  input  logic [7:0]  analog_l,
  input  logic [7:0]  analog_r,
  input  logic        tx_done,
  output logic [79:0] tx_buffer,
  output logic [7:0]  tx_bit_total,
  output logic        tx_start,
  output logic        busy,
  output logic [1:0]  rumble
);

  // Timeout counter runs 0..RX_TIMEOUT_CYCLES-1; the frame is dropped on the last value.
  localparam int TO_W = (RX_TIMEOUT_CYCLES > 2) ? $clog2(RX_TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT_CYCLES - 1);
  // tx_start is registered and EVAL costs one cycle, so TURN ends two counts early.
  localparam int TN_W = (TURNAROUND_CYCLES > 2) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam logic [TN_W-1:0] TURN_LAST = TN_W'((TURNAROUND_CYCLES > 2) ? (TURNAROUND_CYCLES - 2) : 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX   = 3'd1,
    ST_EVAL = 3'd2,
    ST_TURN = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  state_t            state_r, state_next_s;
  logic [7:0]        byte0_r, byte1_r, byte2_r;
  logic [1:0]        count_r;
  logic              ovf_r;
  logic [TO_W-1:0]   timer_r;
  logic [TN_W-1:0]   turn_cnt_r;
  logic [7:0]        org_jx_r, org_jy_r, org_cx_r, org_cy_r, org_l_r, org_r_r;
  logic [79:0]       tx_buffer_r;
  logic [7:0]        tx_bit_total_r;
  logic              tx_start_r, busy_r;
  logic [1:0]        rumble_r;

  logic              cmd_ok_s, load_origin_s, load_rumble_s;
  logic [79:0]       resp_img_s;
  logic [7:0]        resp_bits_s;
  logic [7:0]        resp_b0_s, resp_b1_s;
  logic [47:0]       org_src_s;

  assign tx_buffer    = tx_buffer_r;
  assign tx_bit_total = tx_bit_total_r;
  assign tx_start     = tx_start_r;
  assign busy         = busy_r;
  assign rumble       = rumble_r;

  // Decode the captured frame and build the candidate response image.
  always_comb begin
    cmd_ok_s      = 1'b0;
    load_origin_s = 1'b0;
    load_rumble_s = 1'b0;
    resp_img_s    = 80'h0;
    resp_bits_s   = 8'd0;
    resp_b0_s     = {3'b000, btn[11:7]};
    resp_b1_s     = {1'b1, btn[6:0]};
    // Recalibrate answers with the values being latched, not the old origin.
    org_src_s     = (byte0_r == 8'h42)
                  ? {joy_x, joy_y, cstick_x, cstick_y, analog_l, analog_r}
                  : {org_jx_r, org_jy_r, org_cx_r, org_cy_r, org_l_r, org_r_r};
    case (byte0_r)
      8'h00, 8'hFF: begin
        cmd_ok_s    = (count_r == 2'd1) && !ovf_r;
        resp_img_s  = {24'h090003, 56'h0};
        resp_bits_s = 8'd24;
      end
      8'h40: begin
        cmd_ok_s      = (count_r == 2'd3) && !ovf_r;
        load_rumble_s = (count_r == 2'd3) && !ovf_r;
        resp_img_s    = {resp_b0_s, resp_b1_s, joy_x, joy_y, cstick_x, cstick_y,
                         analog_l, analog_r, 16'h0};
        resp_bits_s   = 8'd64;
      end
      8'h41: begin
        cmd_ok_s    = (count_r == 2'd1) && !ovf_r;
        resp_img_s  = {resp_b0_s, resp_b1_s, org_src_s, 16'h0};
        resp_bits_s = 8'd80;
      end
      8'h42: begin
        cmd_ok_s      = (count_r == 2'd3) && !ovf_r;
        load_origin_s = (count_r == 2'd3) && !ovf_r;
        resp_img_s    = {resp_b0_s, resp_b1_s, org_src_s, 16'h0};
        resp_bits_s   = 8'd80;
      end
      default: begin
        cmd_ok_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for the receive/evaluate/turnaround/send sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) state_next_s = ST_RX;
        else          state_next_s = ST_IDLE;
      end
      ST_RX: begin
        if (rx_stop)                 state_next_s = ST_EVAL;
        else if (rx_valid)           state_next_s = ST_RX;
        else if (timer_r == TO_LAST) state_next_s = ST_IDLE;
        else                         state_next_s = ST_RX;
      end
      ST_EVAL: begin
        if (cmd_ok_s) state_next_s = ST_TURN;
        else          state_next_s = ST_IDLE;
      end
      ST_TURN: begin
        if (turn_cnt_r == TURN_LAST) state_next_s = ST_SEND;
        else                         state_next_s = ST_TURN;
      end
      ST_SEND: begin
        if (tx_done) state_next_s = ST_IDLE;
        else         state_next_s = ST_SEND;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Capture up to three command bytes; any further byte marks the frame as overflowed.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      byte0_r <= 8'h00;
      byte1_r <= 8'h00;
      byte2_r <= 8'h00;
      count_r <= 2'd0;
      ovf_r   <= 1'b0;
    end else if ((state_r == ST_IDLE) && rx_valid) begin
      byte0_r <= rx_byte;
      count_r <= 2'd1;
      ovf_r   <= 1'b0;
    end else if ((state_r == ST_RX) && rx_valid) begin
      case (count_r)
        2'd1: begin
          byte1_r <= rx_byte;
          count_r <= 2'd2;
        end
        2'd2: begin
          byte2_r <= rx_byte;
          count_r <= 2'd3;
        end
        default: ovf_r <= 1'b1;
      endcase
    end
  end

  // Saturating receive-silence and turnaround counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      timer_r    <= '0;
      turn_cnt_r <= '0;
    end else begin
      if ((state_r != ST_RX) || rx_valid || rx_stop) timer_r <= '0;
      else if (timer_r != TO_LAST)                   timer_r <= timer_r + TO_W'(1);
      if (state_r != ST_TURN)           turn_cnt_r <= '0;
      else if (turn_cnt_r != TURN_LAST) turn_cnt_r <= turn_cnt_r + TN_W'(1);
    end
  end

  // Origin (calibration) registers, reloaded by a valid recalibrate command.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      org_jx_r <= 8'h80;
      org_jy_r <= 8'h80;
      org_cx_r <= 8'h80;
      org_cy_r <= 8'h80;
      org_l_r  <= 8'h00;
      org_r_r  <= 8'h00;
    end else if ((state_r == ST_EVAL) && load_origin_s) begin
      org_jx_r <= joy_x;
      org_jy_r <= joy_y;
      org_cx_r <= cstick_x;
      org_cy_r <= cstick_y;
      org_l_r  <= analog_l;
      org_r_r  <= analog_r;
    end
  end

  // Registered outputs: response image, start pulse, busy flag and rumble mode.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_buffer_r    <= 80'h0;
      tx_bit_total_r <= 8'd0;
      tx_start_r     <= 1'b0;
      busy_r         <= 1'b0;
      rumble_r       <= 2'b00;
    end else begin
      tx_start_r <= (state_r == ST_TURN) && (turn_cnt_r == TURN_LAST);
      busy_r     <= (state_next_s == ST_EVAL) || (state_next_s == ST_TURN) ||
                    (state_next_s == ST_SEND);
      if ((state_r == ST_EVAL) && cmd_ok_s) begin
        tx_buffer_r    <= resp_img_s;
        tx_bit_total_r <= resp_bits_s;
      end
      if ((state_r == ST_EVAL) && load_rumble_s) rumble_r <= byte2_r[1:0];
    end
  end

endmodule

// File: tb/tb_gc_response_sequencer.sv
// Self-checking bench for gc_response_sequencer: expected responses are queued
// when a frame's stop bit is driven and compared when tx_start is seen.
`timescale 1ns/1ps
module tb_gc_response_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_stop = 1'b0;
  logic [11:0] btn = 12'h000;
  logic [7:0]  joy_x = 8'h00, joy_y = 8'h00, cstick_x = 8'h00, cstick_y = 8'h00;
  logic [7:0]  analog_l = 8'h00, analog_r = 8'h00;
  logic        tx_done = 1'b0;
  logic [79:0] tx_buffer;
  logic [7:0]  tx_bit_total;
  logic        tx_start;
  logic        busy;
  logic [1:0]  rumble;

  typedef struct {
    logic [79:0] img;
    logic [7:0]  bits;
    logic [1:0]  rum;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stop_cyc = 0;
  int          start_cnt = 0;
  int          start_snap;
  logic [1:0]  rumble_m = 2'b00;
  logic [79:0] last_img_m = 80'h0;

  gc_response_sequencer dut (
    .CLK(CLK), .RESET(RESET), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_stop(rx_stop),
    .btn(btn), .joy_x(joy_x), .joy_y(joy_y), .cstick_x(cstick_x), .cstick_y(cstick_y),
    .analog_l(analog_l), .analog_r(analog_r), .tx_done(tx_done), .tx_buffer(tx_buffer),
    .tx_bit_total(tx_bit_total), .tx_start(tx_start), .busy(busy), .rumble(rumble)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Monitor: every tx_start must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RESET && tx_start) begin
      start_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_tx_start", 80'd1, 80'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("tx_buffer", tx_buffer, e.img);
        check_eq("tx_bit_total", {72'h0, tx_bit_total}, {72'h0, e.bits});
        check_eq("rumble", {78'h0, rumble}, {78'h0, e.rum});
        check_eq("start_latency", 80'(cyc), 80'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rx_b(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic rx_end();
    rx_stop  = 1'b1;
    stop_cyc = cyc;
    tick(1);
    rx_stop  = 1'b0;
  endtask

  task automatic push_exp(input logic [79:0] img, input logic [7:0] bits);
    exp_t e;
    e.img  = img;
    e.bits = bits;
    e.rum  = rumble_m;
    e.cyc  = stop_cyc + 81;
    sb_q.push_back(e);
    last_img_m = img;
  endtask

  // Wait (bounded) for the queued response to start; optionally finish it with tx_done.
  task automatic await_start(input bit finish);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
    if (sb_q.size() != 0) begin
      check_eq("resp_timeout", 80'd0, 80'd1);
      sb_q.delete();
    end
    if (finish) begin
      tick(2);
      check_eq("busy_in_send", {79'h0, busy}, 80'd1);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      tick(1);
      check_eq("busy_after_done", {79'h0, busy}, 80'd0);
    end
  endtask

  task automatic check_no_resp(input string tag);
    tick(120);
    check_eq({tag, "_no_start"}, 80'(start_cnt), 80'(start_snap));
    check_eq({tag, "_busy"}, {79'h0, busy}, 80'd0);
    check_eq({tag, "_buffer"}, tx_buffer, last_img_m);
    check_eq({tag, "_rumble"}, {78'h0, rumble}, {78'h0, rumble_m});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_buffer"}, tx_buffer, 80'h0);
    check_eq({tag, "_bits"}, {72'h0, tx_bit_total}, 80'd0);
    check_eq({tag, "_start"}, {79'h0, tx_start}, 80'd0);
    check_eq({tag, "_busy"}, {79'h0, busy}, 80'd0);
    check_eq({tag, "_rumble"}, {78'h0, rumble}, 80'd0);
  endtask

  initial begin
    tick(3);
    check_reset_outputs("reset");
    RESET = 1'b1;
    tick(2);

    // Get ID
    rx_b(8'h00); rx_end();
    push_exp({24'h090003, 56'h0}, 8'd24);
    await_start(1'b1);

    // Poll with START and A pressed, rumble mode 2
    btn = 12'h880;
    joy_x = 8'h7F; joy_y = 8'h7F; cstick_x = 8'h7F; cstick_y = 8'h7F;
    analog_l = 8'h00; analog_r = 8'h00;
    rx_b(8'h40); rx_b(8'h03); rx_b(8'h02); rx_end();
    rumble_m = 2'b10;
    push_exp({8'h11, 8'h80, 32'h7F7F7F7F, 16'h0000, 16'h0}, 8'd64);
    await_start(1'b1);

    // Origin read returns reset calibration values
    btn = 12'h000;
    rx_b(8'h41); rx_end();
    push_exp(80'h0080_80808080_0000_0000, 8'd80);
    await_start(1'b1);

    // Recalibrate, then read back after the sticks move
    joy_x = 8'h90; joy_y = 8'h6E; cstick_x = 8'h5D; cstick_y = 8'h4C;
    analog_l = 8'h33; analog_r = 8'h22;
    rx_b(8'h42); rx_b(8'hAB); rx_b(8'hCD); rx_end();
    push_exp(80'h0080_906E5D4C_3322_0000, 8'd80);
    await_start(1'b1);
    joy_x = 8'h20; joy_y = 8'h11;
    rx_b(8'h41); rx_end();
    push_exp(80'h0080_906E5D4C_3322_0000, 8'd80);
    await_start(1'b1);

    // Bad frames: none may produce a response or disturb the outputs
    start_snap = start_cnt;
    rx_b(8'h41); rx_b(8'h00); rx_end();
    check_no_resp("bad_extra_byte");
    rx_b(8'h40); rx_end();
    check_no_resp("bad_short_poll");
    rx_b(8'h55); rx_end();
    check_no_resp("bad_cmd");
    rx_stop = 1'b1; tick(1); rx_stop = 1'b0;
    rx_b(8'h40); rx_b(8'h03);
    tick(4100);
    rx_b(8'h02); rx_end();
    check_no_resp("bad_timeout");

    // Reset one cycle after tx_start
    rx_b(8'h00); rx_end();
    push_exp({24'h090003, 56'h0}, 8'd24);
    await_start(1'b0);
    RESET = 1'b0;
    tick(1);
    check_reset_outputs("mid_send_reset");
    RESET = 1'b1;
    rumble_m = 2'b00;
    tick(200);
    check_eq("no_start_after_reset", 80'(start_cnt), 80'(start_snap + 1));
    rx_b(8'h00); rx_end();
    push_exp({24'h090003, 56'h0}, 8'd24);
    await_start(1'b1);
    joy_x = 8'h01;
    rx_b(8'h41); rx_end();
    push_exp(80'h0080_80808080_0000_0000, 8'd80);
    await_start(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
